// File: rtl/spi_mem_core.sv
// SPI-slave (mode 0) memory core: address/RW header, then streamed data words.
// Define SPI_MEM_BURST_EN for auto-incrementing multi-word bursts; otherwise one word per frame.
module spi_mem_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic cs,
    input  logic mosi,
    output logic miso,
    output logic miso_we,
    output logic word_done
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int MAXW  = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam int CW    = $clog2(MAXW) + 1;
`ifdef SPI_MEM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, ADDR, RW, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_STORE, HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic                    sck_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    miso_q, miso_d;
    logic                    miso_we_q, miso_we_d;
    logic                    word_done_q, word_done_d;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic rise, fall, addr_last, data_last;
    assign rise      = sck & ~sck_q;
    assign fall      = ~sck & sck_q;
    assign addr_last = (cnt_q == CW'(ADDR_WIDTH - 1));
    assign data_last = (cnt_q == CW'(DATA_WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sck_q       <= 1'b0;
            addr_q      <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            miso_we_q   <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_q       <= sck;
            addr_q      <= addr_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            miso_we_q   <= miso_we_d;
            word_done_q <= word_done_d;
        end
    end

    // Memory contents survive reset, so the array lives outside the reset block.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= shift_q;
    end

    always_comb begin
        state_d = state_q;
        if (cs) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     state_d = ADDR;
                ADDR:     if (rise && addr_last) state_d = RW;
                RW:       if (rise) state_d = mosi ? RD_LOAD : WR_SHIFT;
                RD_LOAD:  state_d = RD_SHIFT;
                RD_SHIFT: if (rise && data_last) state_d = BURST ? RD_LOAD : HOLD;
                WR_SHIFT: if (rise && data_last) state_d = WR_STORE;
                WR_STORE: state_d = BURST ? WR_SHIFT : HOLD;
                HOLD:     state_d = HOLD;
            endcase
        end
    end

    always_comb begin
        addr_d      = addr_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        miso_d      = miso_q;
        miso_we_d   = miso_we_q;
        word_done_d = 1'b0;
        mem_we      = 1'b0;
        if (cs) begin
            cnt_d     = '0;
            miso_d    = 1'b0;
            miso_we_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: cnt_d = '0;
                ADDR: begin
                    if (rise) begin
                        addr_d = (addr_q << 1) | ADDR_WIDTH'(mosi);
                        cnt_d  = addr_last ? '0 : cnt_q + 1'b1;
                    end
                end
                RW: cnt_d = '0;
                RD_LOAD: begin
                    shift_d   = mem[addr_q];
                    miso_we_d = 1'b1;
                    cnt_d     = '0;
                end
                RD_SHIFT: begin
                    if (fall) begin
                        miso_d  = shift_q[DATA_WIDTH-1];
                        shift_d = shift_q << 1;
                    end
                    if (rise) begin
                        if (data_last) begin
                            word_done_d = 1'b1;
                            cnt_d       = '0;
                            if (BURST) addr_d = addr_q + 1'b1;
                            else       miso_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                WR_SHIFT: begin
                    if (rise) begin
                        shift_d = (shift_q << 1) | DATA_WIDTH'(mosi);
                        cnt_d   = data_last ? '0 : cnt_q + 1'b1;
                    end
                end
                WR_STORE: begin
                    mem_we      = 1'b1;
                    word_done_d = 1'b1;
                    if (BURST) addr_d = addr_q + 1'b1;
                end
                HOLD: ;
            endcase
        end
    end

    assign miso      = miso_q;
    assign miso_we   = miso_we_q;
    assign word_done = word_done_q;
endmodule

// File: tb/tb_spi_mem_core.sv
// Directed bench for spi_mem_core: 8-bit/7-bit and 16-bit/4-bit instances share sck/mosi, separate cs.
module tb_spi_mem_core;
`ifdef SPI_MEM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, mosi = 1'b0;
    logic cs8 = 1'b1, cs16 = 1'b1;
    logic miso8, we8, wd8, miso16, we16, wd16;
    int   n_assert = 0, n_fail = 0;
    int   wd_cnt8 = 0, wd_cnt16 = 0;
    logic [15:0] model [2][128];
    logic [15:0] exp_q [$];
    logic [15:0] wr_q  [$];

    always #5 clk = ~clk;

    spi_mem_core u_dut8 (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs8), .mosi(mosi),
        .miso(miso8), .miso_we(we8), .word_done(wd8)
    );
    spi_mem_core #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs16), .mosi(mosi),
        .miso(miso16), .miso_we(we16), .word_done(wd16)
    );

    always @(negedge clk) begin
        if (wd8)  wd_cnt8  <= wd_cnt8 + 1;
        if (wd16) wd_cnt16 <= wd_cnt16 + 1;
    end

    function automatic int aw_of(input int sel); return sel ? 4 : 7;  endfunction
    function automatic int dw_of(input int sel); return sel ? 16 : 8; endfunction
    function automatic int wdc(input int sel);   return sel ? wd_cnt16 : wd_cnt8; endfunction
    function automatic logic we_of(input int sel);   return sel ? we16 : we8; endfunction
    function automatic logic miso_of(input int sel); return sel ? miso16 : miso8; endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cs(input int sel, input logic v);
        if (sel != 0) cs16 = v; else cs8 = v;
    endtask

    task automatic sck_bit(input logic b, input int sel, output logic m);
        mosi = b;
        repeat (5) @(negedge clk);
        m = miso_of(sel);
        sck = 1'b1;
        repeat (5) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic start_frame(input int sel, input logic [31:0] addr, input logic rw);
        logic m;
        set_cs(sel, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = aw_of(sel) - 1; i >= 0; i--) sck_bit(addr[i], sel, m);
        sck_bit(rw, sel, m);
    endtask

    task automatic end_frame(input int sel);
        repeat (2) @(negedge clk);
        set_cs(sel, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic xfer(input int sel, input logic [31:0] wd, input int nbits, output logic [31:0] rd);
        logic m;
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            sck_bit(wd[dw_of(sel) - 1 - i], sel, m);
            rd = {rd[30:0], m};
        end
    endtask

    // Writes every word queued in wr_q as one frame and updates the reference model.
    task automatic write_frame(input int sel, input int addr, input string tag);
        int d0, n, depth;
        logic [31:0] rd;
        d0 = wdc(sel);
        n = wr_q.size();
        depth = 1 << aw_of(sel);
        start_frame(sel, addr, 1'b0);
        for (int i = 0; i < n; i++) begin
            xfer(sel, {16'h0, wr_q[i]}, dw_of(sel), rd);
            if (BURST || i == 0) model[sel][(addr + i) % depth] = wr_q[i];
        end
        end_frame(sel);
        wr_q.delete();
        check({tag, "_word_done"}, wdc(sel) - d0, BURST ? n : 1);
    endtask

    task automatic read_frame(input int sel, input int addr, input int n, input string tag);
        int d0, depth;
        logic [31:0] rd;
        logic [15:0] e;
        d0 = wdc(sel);
        depth = 1 << aw_of(sel);
        for (int i = 0; i < n; i++)
            exp_q.push_back((BURST || i == 0) ? model[sel][(addr + i) % depth] : 16'h0);
        start_frame(sel, addr, 1'b1);
        for (int i = 0; i < n; i++) begin
            xfer(sel, 32'h0, dw_of(sel), rd);
            if (i == 0) check({tag, "_miso_we_in_frame"}, we_of(sel), 1'b1);
            e = exp_q.pop_front();
            check($sformatf("%s_word%0d", tag, i), rd, {16'h0, e});
        end
        end_frame(sel);
        check({tag, "_word_done"}, wdc(sel) - d0, BURST ? n : 1);
        check({tag, "_miso_we_after"}, we_of(sel), 1'b0);
        check({tag, "_miso_after"}, miso_of(sel), 1'b0);
    endtask

    initial begin
        int d0;
        logic [31:0] rd;

        repeat (3) @(negedge clk);
        check("reset_miso", miso8, 1'b0);
        check("reset_miso_we", we8, 1'b0);
        check("reset_word_done", wd8, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        wr_q.push_back(16'hA5);
        write_frame(0, 'h12, "single_wr");
        read_frame(0, 'h12, 1, "single_rd");

        // Reset in the middle of a write: memory keeps the old word.
        start_frame(0, 'h12, 1'b0);
        xfer(0, 32'h3C, 3, rd);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rstwr_miso", miso8, 1'b0);
        check("rstwr_miso_we", we8, 1'b0);
        cs8 = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        read_frame(0, 'h12, 1, "rstwr_rd");

        // Reset in the middle of a read while miso is driven high.
        start_frame(0, 'h12, 1'b1);
        xfer(0, 32'h0, 2, rd);
        @(negedge clk);
        check("rstrd_pre_miso_we", we8, 1'b1);
        check("rstrd_pre_miso", miso8, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstrd_miso", miso8, 1'b0);
        check("rstrd_miso_we", we8, 1'b0);
        cs8 = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        wr_q.push_back(16'h11); wr_q.push_back(16'h22); wr_q.push_back(16'h33);
        write_frame(0, 'h7E, "burst_wr");
        read_frame(0, 'h7E, 3, "burst_rd");

        // Aborted write leaves memory untouched and raises no word_done.
        wr_q.push_back(16'h5A);
        write_frame(0, 'h05, "abort_pre_wr");
        d0 = wd_cnt8;
        start_frame(0, 'h05, 1'b0);
        xfer(0, 32'hFF, 5, rd);
        cs8 = 1'b1;
        @(negedge clk);
        check("abort_wr_miso_we", we8, 1'b0);
        repeat (4) @(negedge clk);
        check("abort_wr_word_done", wd_cnt8 - d0, 0);
        read_frame(0, 'h05, 1, "abort_rd_back");

        // Aborted read: driver released one clk after cs rises, no word_done.
        d0 = wd_cnt8;
        start_frame(0, 'h05, 1'b1);
        xfer(0, 32'h0, 5, rd);
        check("abort_rd_partial", rd, 32'h0B);
        cs8 = 1'b1;
        @(negedge clk);
        check("abort_rd_miso_we", we8, 1'b0);
        check("abort_rd_miso", miso8, 1'b0);
        repeat (4) @(negedge clk);
        check("abort_rd_word_done", wd_cnt8 - d0, 0);

        wr_q.push_back(16'hBEEF);
        write_frame(1, 'hF, "w16_wr");
        read_frame(1, 'hF, 1, "w16_rd");
        wr_q.push_back(16'h1234); wr_q.push_back(16'h5678);
        write_frame(1, 'hF, "w16_burst_wr");
        read_frame(1, 'hF, 2, "w16_burst_rd");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_mem_core.md
Name: spi_mem_core

Overview:
- Parametrised SPI-slave memory core: the successor to the fixed 8-bit / 7-bit-address SPI memory logic.
- Sits between the input conditioners (which supply synchronised, debounced sck/cs/mosi levels) and the miso tri-state buffer.
- Adds generic data and address widths, burst auto-increment addressing and a per-word completion strobe, in one clk domain.

Parameters:
- DATA_WIDTH, 8, bits per memory word and per SPI data word.
- ADDR_WIDTH, 7, address bits; memory depth is 2**ADDR_WIDTH words (derived localparam DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sck  input  1  conditioned SPI clock level, mode 0 (CPOL=0, CPHA=0).
- cs  input  1  conditioned chip select, active low.
- mosi  input  1  conditioned master-out data.
- miso  output  1  slave-out data, to tri-state buffer.
- miso_we  output  1  tri-state enable for miso.
- word_done  output  1  one-clk pulse per completed word (write stored, or read word fully shifted).

Behaviour:
- Edge detect: sck_q is sck registered on clk. rise = sck & ~sck_q; fall = ~sck & sck_q. Requirement on the master: sck high and low phases each >= 4 clk periods.
- Reset (rst_n=0, async): state=IDLE; miso=0; miso_we=0; word_done=0; address register, shift register and bit counter all 0. Memory contents are not cleared.
- Frame format, MSB first, sampled on rise:
  - ADDR_WIDTH address bits.
  - 1 R/W bit (1=read, 0=write).
  - DATA_WIDTH-bit data words.
- States: IDLE, ADDR, RW, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_STORE, HOLD.
- IDLE: cs=0 -> ADDR, bit counter cleared.
- ADDR: each rise shifts mosi into the address register. After the ADDR_WIDTH-th rise -> RW.
- RW: on rise, mosi=1 -> RD_LOAD; mosi=0 -> WR_SHIFT.
- RD_LOAD: one clk. Shift register <= mem[addr]; miso_we <= 1 and stays 1 until cs deasserts -> RD_SHIFT.
- RD_SHIFT:
  - Each fall: miso <= shift register MSB, then shift left.
  - The DATA_WIDTH-th subsequent rise completes the word: word_done pulses; addr <= addr+1 mod DEPTH; -> RD_LOAD.
  - The next word is therefore ready before the following fall.
- WR_SHIFT: each rise shifts mosi into the shift register. After the DATA_WIDTH-th rise -> WR_STORE.
- WR_STORE: one clk. mem[addr] <= shift register; word_done pulses; addr <= addr+1 mod DEPTH; -> WR_SHIFT.
- HOLD: ignores sck; waits for cs=1.
- cs=1 in any state:
  - Next clk -> IDLE; miso_we=0; miso=0.
  - A partially shifted write word is discarded; memory is unchanged.
  - A partially shifted read word produces no word_done.
- Wrap-around: the address after DEPTH-1 is 0 in both directions of transfer.
- Memory read port is combinational into RD_LOAD. Write is synchronous, single port; a read and a write never coincide.
- sck edges while cs=1 are ignored. An sck edge on the same clk as the cs falling edge is not counted.

Optional Feature:
- Macro SPI_MEM_BURST_EN.
- Defined: multi-word burst as described; address auto-increments after each word until cs rises.
- Undefined:
  - After the first WR_STORE -> HOLD.
  - After the first read word completes -> HOLD, with miso_we held at 1 and miso held at 0 until cs rises.
  - The address register is never incremented; word_done pulses at most once per frame.

Test Plan:
- Reset mid-write: assert rst_n=0 after 3 data bits -> miso=0, miso_we=0, state IDLE; a later read of that address returns its prior value.
- Single write/read, defaults: write 0xA5 to addr 0x12, cs high, then read 0x12 -> miso bits 1,0,1,0,0,1,0,1 on successive falls; miso_we=1 only while cs=0; one word_done each frame.
- Burst write with SPI_MEM_BURST_EN at addr 0x7E: words 0x11, 0x22, 0x33 -> mem[0x7E]=0x11, mem[0x7F]=0x22, mem[0x00]=0x33 (wrap); 3 word_done pulses.
- Burst read of the same 3 words starting at 0x7E -> stream 0x11, 0x22, 0x33.
- Same stimulus with SPI_MEM_BURST_EN undefined -> only 0x11 is transferred; then miso=0; 1 word_done.
- Abort: cs rises after 5 of 8 bits of a write to 0x05 -> mem[0x05] unchanged, no word_done, miso_we=0 next clk.
- Parametrised build DATA_WIDTH=16, ADDR_WIDTH=4: write 0xBEEF to addr 0xF, read back -> 16 bits 0xBEEF MSB first.
